// File: rtl/hvtx_pkg.sv
// Shared TMDS definitions for the hvtx transmit and hvrx receive paths:
// control-period token table and token classification helpers.
package hvtx_pkg;

  typedef enum logic [1:0] {
    CTL_00 = 2'b00,
    CTL_01 = 2'b01,
    CTL_10 = 2'b10,
    CTL_11 = 2'b11
  } tmds_ctl_e;

  // Control tokens indexed by their {vs,hs}-style value, MSB first.
  localparam logic [9:0] CTL_TOKEN [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  function automatic logic tmds_is_ctl(input logic [9:0] w);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w == CTL_TOKEN[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic tmds_ctl_e tmds_ctl_val(input logic [9:0] w);
    tmds_ctl_e r;
    r = CTL_00;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w == CTL_TOKEN[i]) r = tmds_ctl_e'(2'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/hvrx_tmds_dec.sv
// Combinational TMDS symbol decoder: classifies an aligned 10-bit window as a
// control token or a data word and recovers the 8-bit value of data words.
module hvrx_tmds_dec
  import hvtx_pkg::*;
(
  input  logic [9:0] win,
  output logic       is_ctl,
  output logic [1:0] ctl,
  output logic [7:0] data
);

  logic [8:0] q;

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    q       = win[9] ? {win[8], ~win[7:0]} : win[8:0];
    data    = '0;
    data[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      data[i] = q[8] ? (q[i] ^ q[i-1]) : (q[i] ~^ q[i-1]);
    end
    is_ctl = tmds_is_ctl(win);
    ctl    = tmds_ctl_val(win);
  end

endmodule

// File: rtl/hvrx_chan_dec.sv
// TMDS receive channel decoder: hunts for the symbol boundary in a raw 1:10
// deserialized stream using runs of control tokens, then decodes each word.
module hvrx_chan_dec
  import hvtx_pkg::*;
#(
  parameter int unsigned CTL_RUN = 8,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TW      = 13
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_symbol,
  output logic       o_locked,
  output logic [3:0] o_offset,
  output logic       o_de,
  output logic [1:0] o_ctl,
  output logic [7:0] o_data
);

  localparam int unsigned RW = $clog2(CTL_RUN + 1);

  typedef enum logic {
    ST_SEARCH,
    ST_LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  prev_q, prev_d;
  logic [9:0]  win_q, win_d;
  logic [3:0]  offset_q, offset_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic [TW-1:0] to_q, to_d;
  logic        locked_q, locked_d;
  logic        de_q, de_d;
  logic [1:0]  ctl_q, ctl_d;
  logic [7:0]  data_q, data_d;

  logic [19:0] cat;
  logic [3:0]  offset_nxt;
  logic        hit, expiry;
  logic        dec_is_ctl;
  logic [1:0]  dec_ctl;
  logic [7:0]  dec_data;

  hvrx_tmds_dec u_dec (
    .win    (win_q),
    .is_ctl (dec_is_ctl),
    .ctl    (dec_ctl),
    .data   (dec_data)
  );

  // Stage 1: previous word and the window selected by the current offset.
  always_comb begin
    cat    = {i_symbol, prev_q};
    prev_d = i_symbol;
    win_d  = cat[offset_q +: 10];
  end

  // Run/timeout counters and SEARCH/LOCKED transitions; a hit beats expiry.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    run_d      = run_q;
    to_d       = to_q;
    run_inc    = '0;
    if (dec_is_ctl) begin
      run_inc = (run_q == RW'(CTL_RUN)) ? run_q : run_q + RW'(1);
    end
    hit        = dec_is_ctl && (run_q == RW'(CTL_RUN - 1));
    expiry     = (to_q == TW'(TIMEOUT - 1));
    offset_nxt = (offset_q == 4'd9) ? '0 : offset_q + 4'd1;
    if (hit) begin
      state_d = ST_LOCKED;
      run_d   = run_inc;
      to_d    = '0;
    end else if (expiry) begin
      state_d  = ST_SEARCH;
      offset_d = offset_nxt;
      run_d    = '0;
      to_d     = '0;
    end else begin
      run_d = run_inc;
      to_d  = to_q + TW'(1);
    end
  end

  // Stage 2: outputs for the current window; o_ctl holds across data words.
  always_comb begin
    locked_d = (state_q == ST_LOCKED);
    de_d     = 1'b0;
    data_d   = '0;
    ctl_d    = ctl_q;
    if (state_q == ST_SEARCH) begin
      ctl_d = '0;
    end else if (dec_is_ctl) begin
      ctl_d = dec_ctl;
    end else begin
      de_d   = 1'b1;
      data_d = dec_data;
    end
  end

  // All state registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_SEARCH;
      prev_q   <= '0;
      win_q    <= '0;
      offset_q <= '0;
      run_q    <= '0;
      to_q     <= '0;
      locked_q <= 1'b0;
      de_q     <= 1'b0;
      ctl_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      win_q    <= win_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      to_q     <= to_d;
      locked_q <= locked_d;
      de_q     <= de_d;
      ctl_q    <= ctl_d;
      data_q   <= data_d;
    end
  end

  assign o_locked = locked_q;
  assign o_offset = offset_q;
  assign o_de     = de_q;
  assign o_ctl    = ctl_q;
  assign o_data   = data_q;

endmodule

// File: tb/tb_hvrx_chan_dec.sv
// Self-checking bench for hvrx_chan_dec: behavioural model compared every
// cycle, plus literal expectations for lock timing, decode and offset search.
module tb_hvrx_chan_dec;

  localparam int CTL_RUN = 8;
  localparam int TIMEOUT = 4096;
  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic [9:0] i_symbol = '0;
  logic       o_locked;
  logic [3:0] o_offset;
  logic       o_de;
  logic [1:0] o_ctl;
  logic [7:0] o_data;

  always #5 i_clk = ~i_clk;

  hvrx_chan_dec #(.CTL_RUN(CTL_RUN), .TIMEOUT(TIMEOUT), .TW(13)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_symbol (i_symbol),
    .o_locked (o_locked),
    .o_offset (o_offset),
    .o_de     (o_de),
    .o_ctl    (o_ctl),
    .o_data   (o_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;
  int rd = 0;
  bit bq[$];

  // model state
  logic [9:0] m_prev = '0, m_win = '0;
  logic [3:0] m_off = '0;
  bit         m_lock = 0;
  int         m_run = 0, m_to = 0;
  logic       m_olock = 0, m_ode = 0;
  logic [1:0] m_octl = '0;
  logic [7:0] m_odata = '0;

  function automatic int tok_idx(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == TOK[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] w);
    logic [8:0] q;
    logic [7:0] x;
    q = w[9] ? {w[8], ~w[7:0]} : w[8:0];
    x = q[7:0] ^ {q[6:0], 1'b0};
    if (!q[8]) x = x ^ 8'hFE;
    return x;
  endfunction

  task automatic tmds_enc(input logic [7:0] d, output logic [9:0] w);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (rd == 0 || n1q == n0q) begin
      w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (!qm[8]) rd += n0q - n1q; else rd += n1q - n0q;
    end else if ((rd > 0 && n1q > n0q) || (rd < 0 && n0q > n1q)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      rd += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      rd += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  // Behavioural model: one step per clock from the windowing/lock rules.
  always @(posedge i_clk or negedge i_rst_n) begin : model
    int tk;
    logic [19:0] cat;
    logic [9:0] nwin;
    bit hit, expd;
    if (!i_rst_n) begin
      m_prev = '0; m_win = '0; m_off = '0; m_lock = 0; m_run = 0; m_to = 0;
      m_olock = 0; m_ode = 0; m_octl = '0; m_odata = '0;
    end else begin
      tk = tok_idx(m_win);
      m_olock = m_lock;
      if (!m_lock) begin
        m_ode = 0; m_odata = '0; m_octl = '0;
      end else if (tk >= 0) begin
        m_ode = 0; m_odata = '0; m_octl = 2'(tk);
      end else begin
        m_ode = 1; m_odata = tmds_dec(m_win);
      end
      cat  = {i_symbol, m_prev};
      nwin = 10'(cat >> m_off);
      hit  = (tk >= 0) && (m_run == CTL_RUN - 1);
      expd = (m_to == TIMEOUT - 1);
      if (hit) begin
        m_lock = 1; m_to = 0; m_run = CTL_RUN;
      end else if (expd) begin
        m_lock = 0; m_to = 0; m_run = 0;
        m_off = (m_off == 4'd9) ? 4'd0 : m_off + 4'd1;
      end else begin
        m_to++;
        m_run = (tk >= 0) ? ((m_run < CTL_RUN) ? m_run + 1 : CTL_RUN) : 0;
      end
      m_win  = nwin;
      m_prev = i_symbol;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      n_cmp++;
      if ({o_locked, o_offset, o_de, o_ctl, o_data} !==
          {m_olock, m_off, m_ode, m_octl, m_odata}) begin
        n_bad++;
        $display("FAIL model @%0t: got lock=%b off=%0d de=%b ctl=%b data=%h, want lock=%b off=%0d de=%b ctl=%b data=%h",
                 $time, o_locked, o_offset, o_de, o_ctl, o_data,
                 m_olock, m_off, m_ode, m_octl, m_odata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [9:0] w);
    i_symbol = w;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_data();
    logic [9:0] w;
    tmds_enc(8'($urandom_range(0, 255)), w);
    send(w);
  endtask

  task automatic refill();
    logic [9:0] w;
    for (int i = 0; i < 12; i++) for (int b = 0; b < 10; b++) bq.push_back(T0[b]);
    for (int i = 0; i < 40; i++) begin
      tmds_enc(8'($urandom_range(0, 255)), w);
      for (int b = 0; b < 10; b++) bq.push_back(w[b]);
    end
  endtask

  task automatic send_wire();
    logic [9:0] w;
    if (bq.size() < 10) refill();
    for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
    send(w);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  task automatic scen_lock(input string tag);
    for (int k = 1; k <= 20; k++) begin
      send(T0);
      if (k == 10) check({tag, "_unlocked_k10"}, 32'(o_locked), 32'd0);
      if (k == 11) begin
        check({tag, "_locked_k11"}, 32'(o_locked), 32'd1);
        check({tag, "_ctl_k11"}, 32'(o_ctl), 32'd0);
        check({tag, "_de_k11"}, 32'(o_de), 32'd0);
      end
    end
    send(10'h100); send(10'h100); send(10'h100);
    check({tag, "_de_100"}, 32'(o_de), 32'd1);
    check({tag, "_data_100"}, 32'(o_data), 32'h00);
    check({tag, "_ctl_held"}, 32'(o_ctl), 32'd0);
    send(10'h200); send(10'h100); send(10'h100);
    check({tag, "_de_200"}, 32'(o_de), 32'd1);
    check({tag, "_data_200"}, 32'(o_data), 32'hFF);
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_offset", 32'(o_offset), 32'd0);
    check("rst_de", 32'(o_de), 32'd0);
    check("rst_ctl", 32'(o_ctl), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    i_rst_n = 1'b1;
    cmp_en = 1;

    // first lock at offset 0 and simple decode
    scen_lock("s1");

    // full 256-byte encoder stream
    begin
      logic [9:0] words [256];
      rd = 0;
      for (int b = 0; b < 256; b++) tmds_enc(8'(b), words[b]);
      for (int j = 0; j < 258; j++) begin
        send(j < 256 ? words[j] : T0);
        if (j >= 2) begin
          check("byte_de", 32'(o_de), 32'd1);
          check("byte_val", 32'(o_data), 32'(j - 2));
        end
      end
    end

    // wire stream missing its first 7 bits -> boundary found at offset 3
    do_reset();
    rd = 0;
    bq.delete();
    refill();
    for (int b = 0; b < 7; b++) void'(bq.pop_front());
    for (int c = 0; c < 20000 && !o_locked; c++) send_wire();
    check("rot_locked", 32'(o_locked), 32'd1);
    check("rot_offset", 32'(o_offset), 32'd3);
    for (int c = 0; c < 300; c++) send_wire();
    check("rot_still_locked", 32'(o_locked), 32'd1);

    // data only -> lock times out, offset advances by one
    for (int c = 0; c < TIMEOUT + 100 && o_locked; c++) send_data();
    check("to_unlocked", 32'(o_locked), 32'd0);
    check("to_offset", 32'(o_offset), 32'd4);

    // offset 9 wraps to 0 on expiry
    for (int c = 0; c < 6 * TIMEOUT && o_offset != 4'd9; c++) send_data();
    check("reach_off9", 32'(o_offset), 32'd9);
    for (int c = 0; c < TIMEOUT + 100 && o_offset == 4'd9; c++) send_data();
    check("wrap_off0", 32'(o_offset), 32'd0);
    check("wrap_unlocked", 32'(o_locked), 32'd0);

    // CTL_RUN-th token lands on the expiry cycle -> lock wins, offset kept
    for (int c = 0; c < TIMEOUT + 100 && m_to != TIMEOUT - 10; c++) send_data();
    check("sync_to", 32'(m_to), 32'(TIMEOUT - 10));
    for (int k = 0; k < CTL_RUN + 3; k++) send(T0);
    check("race_locked", 32'(o_locked), 32'd1);
    check("race_offset", 32'(o_offset), 32'd0);

    // async reset mid-stream while locked
    send(10'h100); send(10'h100);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_locked", 32'(o_locked), 32'd0);
    check("arst_offset", 32'(o_offset), 32'd0);
    check("arst_de", 32'(o_de), 32'd0);
    check("arst_ctl", 32'(o_ctl), 32'd0);
    check("arst_data", 32'(o_data), 32'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    scen_lock("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
